// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480 text-mode video path.
// Timing values describe the upstream controller; the renderer only needs the text geometry.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int GLYPH_W   = 8;
  localparam int GLYPH_H   = 16;

  // The underline cursor occupies the last two glyph rows.
  localparam logic [3:0] UL_FIRST_ROW = 4'(GLYPH_H - 2);

  typedef logic [7:0] color_t;

  typedef struct packed {
    logic [2:0] col;
    logic [3:0] row;
    logic       hit;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank_n;
  } pipe_t;

  localparam pipe_t PIPE_RESET = '{col: 3'd0, row: 4'd0, hit: 1'b0,
                                   hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0};

  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return 12'(row) * 12'(TEXT_COLS) + 12'(col);
  endfunction

endpackage

// File: rtl/text_cursor_ctrl.sv
// Cursor position registers with range-checked load, plus the frame-counted blink phase.
module text_cursor_ctrl
  import vga_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       cursor_we,
  input  logic [6:0] cursor_x,
  input  logic [4:0] cursor_y,
  input  logic       new_frame,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic       visible
);

  logic [6:0] cur_x_d, cur_x_q;
  logic [4:0] cur_y_d, cur_y_q;
  logic [5:0] blink_cnt_d, blink_cnt_q;
  logic       phase_d, phase_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    if (cursor_we && (cursor_x < 7'(TEXT_COLS)) && (cursor_y < 5'(TEXT_ROWS))) begin
      cur_x_d = cursor_x;
      cur_y_d = cursor_y;
    end

    if (new_frame) begin
      if (blink_cnt_q == 6'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 6'd1;
      end
    end
  end

  // NOTE: non-blocking assignments so all flops sample the pre-edge values together.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign cur_x   = cur_x_q;
  assign cur_y   = cur_y_q;
  assign visible = phase_q;

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode pixel generator: character fetch, glyph fetch and colour select,
// with sync/blank carried alongside so every output is exactly three clocks behind its input.
module vga_text_renderer
  import vga_pkg::*;
#(
  parameter color_t FG_COLOR     = 8'hFF,
  parameter color_t BG_COLOR     = 8'h00,
  parameter int     BLINK_FRAMES = 30
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync_n_in,
  input  logic        vsync_n_in,
  input  logic        blank_n_in,
  input  logic        new_frame,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_we,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  input  logic        cursor_en,
  output logic [7:0]  color,
  output logic        hsync_n_out,
  output logic        vsync_n_out,
  output logic        blank_n_out
);

  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       cur_visible;

  text_cursor_ctrl #(.BLINK_FRAMES(BLINK_FRAMES)) u_cursor (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .cursor_we (cursor_we),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .new_frame (new_frame),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .visible   (cur_visible)
  );

  pipe_t  stage1_d, stage1_q;
  pipe_t  stage2_d, stage2_q;
  color_t color_d, color_q;
  logic   hsync_n_d, hsync_n_q;
  logic   vsync_n_d, vsync_n_q;
  logic   blank_n_d, blank_n_q;
  logic   pixel;

  // Line 480+ is always blanked, so the top bit of vcount never selects a cell.
  logic unused_vcount_msb;
  assign unused_vcount_msb = vcount[9];

  always_comb begin
    stage1_d         = PIPE_RESET;
    stage1_d.col     = hcount[2:0];
    stage1_d.row     = vcount[3:0];
    stage1_d.hit     = cursor_en && cur_visible &&
                       (hcount[9:3] == cur_x) && (vcount[8:4] == cur_y) &&
                       (vcount[3:0] >= UL_FIRST_ROW);
    stage1_d.hsync_n = hsync_n_in;
    stage1_d.vsync_n = vsync_n_in;
    stage1_d.blank_n = blank_n_in;

    char_addr = blank_n_in ? cell_addr(vcount[8:4], hcount[9:3]) : '0;
  end

  // char_data lines up with stage1, font_data with stage2.
  assign font_addr = {char_data, stage1_q.row};
  assign stage2_d  = stage1_q;
  assign pixel     = font_data[3'd7 - stage2_q.col];

  always_comb begin
    color_d   = '0;
    hsync_n_d = stage2_q.hsync_n;
    vsync_n_d = stage2_q.vsync_n;
    blank_n_d = stage2_q.blank_n;
    if (stage2_q.blank_n) begin
      color_d = (pixel ^ stage2_q.hit) ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      stage1_q  <= PIPE_RESET;
      stage2_q  <= PIPE_RESET;
      color_q   <= '0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      stage1_q  <= stage1_d;
      stage2_q  <= stage2_d;
      color_q   <= color_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign color       = color_q;
  assign hsync_n_out = hsync_n_q;
  assign vsync_n_out = vsync_n_q;
  assign blank_n_out = blank_n_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Self-checking bench for vga_text_renderer: directed scenarios followed by random pixels,
// all compared against a cell/glyph-level reference model of the text screen.
module tb_vga_text_renderer;

  localparam logic [7:0] FG    = 8'hFF;
  localparam logic [7:0] BG    = 8'h00;
  localparam int         BLINK = 30;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  hcount, vcount;
  logic        hsync_n_in, vsync_n_in, blank_n_in, new_frame;
  logic [11:0] char_addr, font_addr;
  logic [7:0]  char_data, font_data;
  logic        cursor_we, cursor_en;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [7:0]  color;
  logic        hsync_n_out, vsync_n_out, blank_n_out;

  vga_text_renderer dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync_n_in  (hsync_n_in),
    .vsync_n_in  (vsync_n_in),
    .blank_n_in  (blank_n_in),
    .new_frame   (new_frame),
    .char_addr   (char_addr),
    .char_data   (char_data),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .cursor_we   (cursor_we),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .cursor_en   (cursor_en),
    .color       (color),
    .hsync_n_out (hsync_n_out),
    .vsync_n_out (vsync_n_out),
    .blank_n_out (blank_n_out)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous text RAM and font ROM, one-cycle read latency.
  logic [7:0] text_mem [0:4095];
  logic [7:0] font_mem [0:4095];
  always @(posedge vga_clk) begin
    char_data <= text_mem[char_addr];
    font_data <= font_mem[font_addr];
  end

  typedef struct packed {
    logic [7:0] color;
    logic       hs;
    logic       vs;
    logic       bl;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cx = 0, m_cy = 0, frames = 0;
  bit   cur_en = 1'b0;

  task automatic check(string tag, logic [11:0] obs, logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cursor_visible();
    return ((frames / BLINK) % 2) == 0;
  endfunction

  function automatic logic [7:0] model_color(int h, int v, bit bl, bit en);
    int         ccol, crow, grow, gcol;
    logic [7:0] ch, bits;
    bit         pix, hit;
    if (!bl) return 8'h00;
    ccol = h / 8;
    crow = v / 16;
    gcol = h % 8;
    grow = v % 16;
    ch   = text_mem[crow * 80 + ccol];
    bits = font_mem[int'(ch) * 16 + grow];
    pix  = bits[7 - gcol];
    hit  = en && cursor_visible() && ccol == m_cx && crow == m_cy && grow >= 14;
    return (pix ^ hit) ? FG : BG;
  endfunction

  // Drive one pixel at the falling edge, then check the pixel driven three steps earlier.
  task automatic step(int h, int v, bit nf = 1'b0, bit we = 1'b0, int cx = 0, int cy = 0);
    exp_t e;
    bit bl, hs, vs;
    bl = (h < 640) && (v < 480);
    hs = !(h >= 656 && h < 752);
    vs = !(v >= 490 && v < 492);
    hcount     = 10'(h);
    vcount     = 10'(v);
    blank_n_in = bl;
    hsync_n_in = hs;
    vsync_n_in = vs;
    new_frame  = nf;
    cursor_we  = we;
    cursor_x   = 7'(cx);
    cursor_y   = 5'(cy);
    cursor_en  = cur_en;
    e.color = model_color(h, v, bl, cur_en);
    e.hs    = hs;
    e.vs    = vs;
    e.bl    = bl;
    q.push_back(e);
    #1 check("char_addr", char_addr, bl ? 12'((v / 16) * 80 + h / 8) : 12'd0);
    if (we && cx < 80 && cy < 30) begin
      m_cx = cx;
      m_cy = cy;
    end
    if (nf) frames++;
    @(negedge vga_clk);
    if (q.size() == 3) begin
      e = q.pop_front();
      check("color", 12'(color), 12'(e.color));
      check("hsync_n_out", 12'(hsync_n_out), 12'(e.hs));
      check("vsync_n_out", 12'(vsync_n_out), 12'(e.vs));
      check("blank_n_out", 12'(blank_n_out), 12'(e.bl));
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cx   = 0;
    m_cy   = 0;
    frames = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      text_mem[i] = 8'($urandom);
      font_mem[i] = 8'($urandom);
    end
    text_mem[0]        = 8'h41;
    font_mem[12'h410]  = 8'h80;
    text_mem[2*80 + 5] = 8'h20;
    for (int r = 0; r < 16; r++) font_mem[12'h200 + r] = 8'h00;

    reset_n    = 1'b0;
    hcount     = '0;
    vcount     = '0;
    hsync_n_in = 1'b1;
    vsync_n_in = 1'b1;
    blank_n_in = 1'b0;
    new_frame  = 1'b0;
    cursor_we  = 1'b0;
    cursor_x   = '0;
    cursor_y   = '0;
    cursor_en  = 1'b0;
    repeat (3) @(negedge vga_clk);
    check("reset_color", 12'(color), 12'h0);
    check("reset_hsync", 12'(hsync_n_out), 12'h1);
    check("reset_vsync", 12'(vsync_n_out), 12'h1);
    check("reset_blank", 12'(blank_n_out), 12'h0);
    reset_n = 1'b1;

    // Cell (0,0) glyph row 0 has only its leftmost pixel set.
    step(0, 0); step(1, 0); step(2, 0);
    check("cell00_h0_fg", 12'(color), 12'(FG));
    step(3, 0);
    check("cell00_h1_bg", 12'(color), 12'(BG));

    // Blanked pixel: address forced to zero, colour black.
    step(645, 100); step(646, 100); step(647, 100);
    check("blank_color", 12'(color), 12'h0);
    check("blank_out", 12'(blank_n_out), 12'h0);

    // hsync falls at h=656, vsync at v=490; both seen three clocks later.
    for (int h = 653; h <= 657; h++) step(h, 10);
    check("hsync_before_edge", 12'(hsync_n_out), 12'h1);
    step(658, 10);
    check("hsync_after_edge", 12'(hsync_n_out), 12'h0);
    for (int v = 487; v <= 491; v++) step(0, v);
    check("vsync_before_edge", 12'(vsync_n_out), 12'h1);
    step(0, 492);
    check("vsync_after_edge", 12'(vsync_n_out), 12'h0);

    // Underline cursor at (5,2) over a blank glyph.
    cur_en = 1'b1;
    step(700, 500, 1'b0, 1'b1, 5, 2);
    for (int v = 45; v <= 47; v++)
      for (int h = 40; h <= 47; h++) step(h, v);
    step(40, 46); step(41, 46); step(42, 46);
    check("cursor_row46", 12'(color), 12'(FG));
    step(40, 45); step(41, 45); step(42, 45);
    check("cursor_row45", 12'(color), 12'(BG));

    // Out-of-range writes are ignored.
    step(700, 500, 1'b0, 1'b1, 80, 2);
    step(700, 500, 1'b0, 1'b1, 3, 30);
    step(40, 47); step(41, 47); step(42, 47);
    check("cursor_kept", 12'(color), 12'(FG));

    // Thirty frames hide the cursor.
    for (int i = 0; i < BLINK; i++) step(700, 500, 1'b1);
    for (int h = 40; h <= 47; h++) step(h, 46);
    step(40, 47); step(41, 47); step(42, 47);
    check("cursor_blink_off", 12'(color), 12'(BG));

    // Asynchronous reset mid-line while an FG pixel is on the output.
    cur_en = 1'b0;
    step(0, 0); step(1, 0); step(2, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_color", 12'(color), 12'h0);
    check("midreset_hsync", 12'(hsync_n_out), 12'h1);
    check("midreset_vsync", 12'(vsync_n_out), 12'h1);
    check("midreset_blank", 12'(blank_n_out), 12'h0);
    model_reset();
    @(negedge vga_clk);
    reset_n = 1'b1;
    step(0, 0); step(1, 0); step(2, 0);
    check("postreset_fg", 12'(color), 12'(FG));

    // Random pixels, cursor moves and frame pulses.
    for (int i = 0; i < 2500; i++) begin
      int h, v;
      cur_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        h = m_cx * 8 + $urandom_range(0, 7);
        v = m_cy * 16 + $urandom_range(12, 15);
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
      end
      step(h, v, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 99), $urandom_range(0, 31));
    end
    step(700, 500); step(700, 500); step(700, 500);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
